// File: rtl/cse_x25_axilite_rr_arbiter.sv
// Round-robin arbiter that shares one AXI-Lite slave among num_req_p simple requesters,
// with one transaction in flight and the response routed back to the granted requester.
module cse_x25_axilite_rr_arbiter #(
    parameter int num_req_p        = 2,
    parameter int axi_addr_width_p = 32,
    parameter int axi_data_width_p = 32,
    parameter int lg_num_req_lp    = $clog2(num_req_p)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [num_req_p-1:0]                  req_v_i,
    input  logic [num_req_p-1:0]                  req_we_i,
    input  logic [num_req_p*axi_addr_width_p-1:0] req_addr_i,
    input  logic [num_req_p*axi_data_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]                  req_ready_o,
    output logic [num_req_p-1:0]                  resp_v_o,
    output logic [axi_data_width_p-1:0]           resp_data_o,
    output logic                                  resp_err_o,
    input  logic [num_req_p-1:0]                  resp_ready_i,
    output logic [axi_addr_width_p-1:0]           m_axi_awaddr_o,
    output logic                                  m_axi_awvalid_o,
    input  logic                                  m_axi_awready_i,
    output logic [axi_data_width_p-1:0]           m_axi_wdata_o,
    output logic                                  m_axi_wvalid_o,
    input  logic                                  m_axi_wready_i,
    input  logic [1:0]                            m_axi_bresp_i,
    input  logic                                  m_axi_bvalid_i,
    output logic                                  m_axi_bready_o,
    output logic [axi_addr_width_p-1:0]           m_axi_araddr_o,
    output logic                                  m_axi_arvalid_o,
    input  logic                                  m_axi_arready_i,
    input  logic [axi_data_width_p-1:0]           m_axi_rdata_i,
    input  logic [1:0]                            m_axi_rresp_i,
    input  logic                                  m_axi_rvalid_i,
    output logic                                  m_axi_rready_o
);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP
    } state_e;

    state_e                      state;
    logic [lg_num_req_lp-1:0]    last_r, grant_r, winner;
    logic                        found;
    logic [axi_addr_width_p-1:0] addr_r;
    logic [axi_data_width_p-1:0] data_r;
    logic                        aw_done_r, w_done_r;
    logic                        aw_hs, w_hs;
    logic [num_req_p-1:0]        resp_v_r;
    logic [axi_data_width_p-1:0] resp_data_r;
    logic                        resp_err_r;
    logic [num_req_p-1:0]        one_hot_base;

    assign one_hot_base = {{(num_req_p-1){1'b0}}, 1'b1};

    // Scan starts just after the last winner, so each requester waits at most N-1 grants.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        winner = last_r;
        found  = 1'b0;
        for (int unsigned k = 1; k <= num_req_p; k++) begin
            idx = (32'(last_r) + k) % 32'(num_req_p);
            if (!found && req_v_i[idx]) begin
                winner = lg_num_req_lp'(idx);
                found  = 1'b1;
            end
        end
    end

    assign req_ready_o = (state == IDLE && found) ? (one_hot_base << winner) : '0;

    assign m_axi_awvalid_o = (state == WR_ADDR_DATA) && !aw_done_r;
    assign m_axi_wvalid_o  = (state == WR_ADDR_DATA) && !w_done_r;
    assign m_axi_awaddr_o  = (state == WR_ADDR_DATA) ? addr_r : '0;
    assign m_axi_wdata_o   = (state == WR_ADDR_DATA) ? data_r : '0;
    assign m_axi_bready_o  = (state == WR_RESP);
    assign m_axi_arvalid_o = (state == RD_ADDR);
    assign m_axi_araddr_o  = (state == RD_ADDR) ? addr_r : '0;
    assign m_axi_rready_o  = (state == RD_DATA);

    assign aw_hs = m_axi_awvalid_o && m_axi_awready_i;
    assign w_hs  = m_axi_wvalid_o && m_axi_wready_i;

    assign resp_v_o    = resp_v_r;
    assign resp_data_o = resp_data_r;
    assign resp_err_o  = resp_err_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            last_r      <= lg_num_req_lp'(num_req_p - 1);
            grant_r     <= '0;
            addr_r      <= '0;
            data_r      <= '0;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            resp_v_r    <= '0;
            resp_data_r <= '0;
            resp_err_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_r   <= winner;
                        last_r    <= winner;
                        addr_r    <= req_addr_i[winner*axi_addr_width_p +: axi_addr_width_p];
                        data_r    <= req_data_i[winner*axi_data_width_p +: axi_data_width_p];
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        state     <= req_we_i[winner] ? WR_ADDR_DATA : RD_ADDR;
                    end
                end
                WR_ADDR_DATA: begin
                    // AW and W complete independently; leave once both have (same cycle included).
                    if (aw_hs) aw_done_r <= 1'b1;
                    if (w_hs)  w_done_r  <= 1'b1;
                    if ((aw_done_r || aw_hs) && (w_done_r || w_hs)) state <= WR_RESP;
                end
                WR_RESP: begin
                    if (m_axi_bvalid_i) begin
                        resp_err_r  <= (m_axi_bresp_i != 2'b00);
                        resp_data_r <= '0;
                        resp_v_r    <= one_hot_base << grant_r;
                        state       <= RESP;
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arready_i) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (m_axi_rvalid_i) begin
                        resp_err_r  <= (m_axi_rresp_i != 2'b00);
                        resp_data_r <= m_axi_rdata_i;
                        resp_v_r    <= one_hot_base << grant_r;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i[grant_r]) begin
                        resp_v_r <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
